mem_rsp_gather: RTL and testbench

//   Reassembles the partial read responses a memory coalescer returns for one warp request into a single full-width response.

---
 rtl/mem_rsp_gather.sv | 145 ++++++++++++++
 tb/tb_mem_rsp_gather.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rsp_gather.sv
// Merges per-tag partial read fragments into one full response; final fragment -> out_rsp_valid in 1 cycle.
// Backpressure: in_rsp_ready drops while a merged response is held with out_rsp_ready low.
module mem_rsp_gather #(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int UUID_WIDTH  = 0,
  parameter int QUEUE_SIZE  = 8,
  parameter int QUEUE_ADDRW = $clog2(QUEUE_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_en,
  input  logic [QUEUE_ADDRW-1:0]         alloc_idx,
  input  logic [NUM_REQS-1:0]            alloc_mask,
  input  logic                           in_rsp_valid,
  input  logic [NUM_REQS-1:0]            in_rsp_mask,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_rsp_data,
  input  logic [TAG_WIDTH-1:0]           in_rsp_tag,
  output logic                           in_rsp_ready,
  output logic                           out_rsp_valid,
  output logic [NUM_REQS-1:0]            out_rsp_mask,
  output logic [NUM_REQS*DATA_WIDTH-1:0] out_rsp_data,
  output logic [TAG_WIDTH-1:0]           out_rsp_tag,
  input  logic                           out_rsp_ready,
  output logic                           idle
);

  localparam int DW       = NUM_REQS * DATA_WIDTH;
  localparam int REQ_TAGW = TAG_WIDTH - UUID_WIDTH;

  // The entry index must fit below the UUID field of the tag.
  if (REQ_TAGW < QUEUE_ADDRW) begin : g_tag_check
    $error("mem_rsp_gather: tag too narrow for queue index");
  end

  logic [QUEUE_SIZE-1:0] valid_q, valid_d;
  logic [NUM_REQS-1:0]   exp_q  [QUEUE_SIZE];
  logic [NUM_REQS-1:0]   exp_d  [QUEUE_SIZE];
  logic [NUM_REQS-1:0]   rcv_q  [QUEUE_SIZE];
  logic [NUM_REQS-1:0]   rcv_d  [QUEUE_SIZE];
  logic [DW-1:0]         data_q [QUEUE_SIZE];
  logic [DW-1:0]         data_d [QUEUE_SIZE];

  logic                  out_valid_q, out_valid_d;
  logic [NUM_REQS-1:0]   out_mask_q, out_mask_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

  logic [QUEUE_ADDRW-1:0] rsp_idx;
  logic                   rsp_fire;
  logic                   rsp_done;
  logic [NUM_REQS-1:0]    rcv_n;
  logic [DW-1:0]          merged;

  assign rsp_idx      = in_rsp_tag[QUEUE_ADDRW-1:0];
  assign in_rsp_ready = ~out_valid_q | out_rsp_ready;
  assign rsp_fire     = in_rsp_valid & in_rsp_ready;
  assign rcv_n        = rcv_q[rsp_idx] | in_rsp_mask;
  assign rsp_done     = rsp_fire & (rcv_n == exp_q[rsp_idx]);

  always_comb begin
    merged = data_q[rsp_idx];
    for (int l = 0; l < NUM_REQS; l++) begin
      if (in_rsp_mask[l]) merged[l*DATA_WIDTH +: DATA_WIDTH] = in_rsp_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    valid_d     = valid_q;
    exp_d       = exp_q;
    rcv_d       = rcv_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (out_valid_q && out_rsp_ready) out_valid_d = 1'b0;

    if (rsp_done) begin
      out_valid_d      = 1'b1;
      out_mask_d       = exp_q[rsp_idx];
      out_data_d       = merged;
      out_tag_d        = in_rsp_tag;
      valid_d[rsp_idx] = 1'b0;
    end else if (rsp_fire) begin
      rcv_d[rsp_idx]  = rcv_n;
      data_d[rsp_idx] = merged;
    end

    // Applied last so a same-index completion is re-armed by the new request.
    if (alloc_en) begin
      valid_d[alloc_idx] = 1'b1;
      exp_d[alloc_idx]   = alloc_mask;
      rcv_d[alloc_idx]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        exp_q[i] <= '0;
        rcv_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      rcv_q       <= rcv_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q     <= data_d;
    out_mask_q <= out_mask_d;
    out_data_q <= out_data_d;
    out_tag_q  <= out_tag_d;
  end

  assign out_rsp_valid = out_valid_q;
  assign out_rsp_mask  = out_mask_q;
  assign out_rsp_data  = out_data_q;
  assign out_rsp_tag   = out_tag_q;
  assign idle          = ~(|valid_q) & ~out_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc_en) begin
        assert (alloc_mask != '0) else $error("mem_rsp_gather: empty alloc mask");
        assert (!(valid_q[alloc_idx] && !(rsp_done && rsp_idx == alloc_idx)))
          else $error("mem_rsp_gather: alloc of busy entry %0d", alloc_idx);
      end
      if (rsp_fire) begin
        assert (valid_q[rsp_idx]) else $error("mem_rsp_gather: fragment to idle entry %0d", rsp_idx);
        assert (in_rsp_mask != '0) else $error("mem_rsp_gather: empty fragment mask");
        assert ((in_rsp_mask & ~exp_q[rsp_idx]) == '0) else $error("mem_rsp_gather: unexpected lanes");
        assert ((in_rsp_mask & rcv_q[rsp_idx]) == '0) else $error("mem_rsp_gather: duplicate lanes");
      end
    end
  end

endmodule

// File: tb/tb_mem_rsp_gather.sv
// Directed bench for mem_rsp_gather: hand-computed merge results, handshake and reset scenarios.
module tb_mem_rsp_gather;

  logic         clk = 1'b0;
  logic         reset;
  logic         alloc_en;
  logic [2:0]   alloc_idx;
  logic [3:0]   alloc_mask;
  logic         in_rsp_valid;
  logic [3:0]   in_rsp_mask;
  logic [127:0] in_rsp_data;
  logic [7:0]   in_rsp_tag;
  logic         in_rsp_ready;
  logic         out_rsp_valid;
  logic [3:0]   out_rsp_mask;
  logic [127:0] out_rsp_data;
  logic [7:0]   out_rsp_tag;
  logic         out_rsp_ready;
  logic         idle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_rsp_gather dut (
    .clk(clk), .reset(reset),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .alloc_mask(alloc_mask),
    .in_rsp_valid(in_rsp_valid), .in_rsp_mask(in_rsp_mask), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_mask(out_rsp_mask), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready), .idle(idle)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; alloc_en = 1'b0; alloc_idx = '0; alloc_mask = '0;
    in_rsp_valid = 1'b0; in_rsp_mask = '0; in_rsp_data = '0; in_rsp_tag = '0;
    out_rsp_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_rsp_valid); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", idle); end
    n_vec++; if (in_rsp_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_rsp_ready); end
  endtask

  task automatic test_single();
    logic [127:0] d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    alloc_en = 1'b1; alloc_idx = 3'd2; alloc_mask = 4'b1111;
    cyc();
    alloc_en = 1'b0;
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_armed_idle got %b want 0", idle); end
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b1111; in_rsp_data = d; in_rsp_tag = 8'h42;
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_rsp_valid); end
    n_vec++; if (out_rsp_mask !== 4'b1111) begin n_err++; $display("FAIL single_mask got %b want 1111", out_rsp_mask); end
    n_vec++; if (out_rsp_data !== d) begin n_err++; $display("FAIL single_data got %h want %h", out_rsp_data, d); end
    n_vec++; if (out_rsp_tag !== 8'h42) begin n_err++; $display("FAIL single_tag got %h want 42", out_rsp_tag); end
    cyc();
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drop got %b want 0", out_rsp_valid); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle got %b want 1", idle); end
  endtask

  task automatic test_partial();
    logic [127:0] m = {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [127:0] e = {32'hB3B3_B3B3, 32'h0, 32'hB1B1_B1B1, 32'hAAAA_0000};
    alloc_en = 1'b1; alloc_idx = 3'd1; alloc_mask = 4'b1011;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0001; in_rsp_tag = 8'h11;
    in_rsp_data = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hAAAA_0000};
    cyc();
    in_rsp_mask = 4'b1010; in_rsp_tag = 8'h21;
    in_rsp_data = {32'hB3B3_B3B3, 32'h5555_5555, 32'hB1B1_B1B1, 32'h5555_5555};
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL partial_early got %b want 0", out_rsp_valid); end
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1) begin n_err++; $display("FAIL partial_valid got %b want 1", out_rsp_valid); end
    n_vec++; if (out_rsp_mask !== 4'b1011) begin n_err++; $display("FAIL partial_mask got %b want 1011", out_rsp_mask); end
    n_vec++; if ((out_rsp_data & m) !== e) begin n_err++; $display("FAIL partial_data got %h want %h", out_rsp_data & m, e); end
    n_vec++; if (out_rsp_tag !== 8'h21) begin n_err++; $display("FAIL partial_tag got %h want 21", out_rsp_tag); end
    cyc();
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL partial_once got %b want 0", out_rsp_valid); end
  endtask

  task automatic test_interleave();
    logic [127:0] m0 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [127:0] m5 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    alloc_en = 1'b1; alloc_idx = 3'd0; alloc_mask = 4'b0011;
    cyc();
    alloc_idx = 3'd5; alloc_mask = 4'b1100;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0100; in_rsp_tag = 8'h05;
    in_rsp_data = {32'h0, 32'hC2C2_C2C2, 32'h0, 32'h0};
    cyc();
    n_vec++; if (out_rsp_valid !== 1'b0) begin n_err++; $display("FAIL ilv_partial got %b want 0", out_rsp_valid); end
    in_rsp_mask = 4'b0011; in_rsp_tag = 8'h80;
    in_rsp_data = {32'h9999_9999, 32'h9999_9999, 32'hE1E1_E1E1, 32'hE0E0_E0E0};
    cyc();
    in_rsp_mask = 4'b1000; in_rsp_tag = 8'h85;
    in_rsp_data = {32'hC3C3_C3C3, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777};
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h80 || out_rsp_mask !== 4'b0011)
      begin n_err++; $display("FAIL ilv_first got v=%b tag=%h mask=%b want v=1 tag=80 mask=0011", out_rsp_valid, out_rsp_tag, out_rsp_mask); end
    n_vec++; if ((out_rsp_data & m0) !== {64'h0, 32'hE1E1_E1E1, 32'hE0E0_E0E0})
      begin n_err++; $display("FAIL ilv_first_data got %h want e1e1e1e1e0e0e0e0", out_rsp_data & m0); end
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h85 || out_rsp_mask !== 4'b1100)
      begin n_err++; $display("FAIL ilv_second got v=%b tag=%h mask=%b want v=1 tag=85 mask=1100", out_rsp_valid, out_rsp_tag, out_rsp_mask); end
    n_vec++; if ((out_rsp_data & m5) !== {32'hC3C3_C3C3, 32'hC2C2_C2C2, 64'h0})
      begin n_err++; $display("FAIL ilv_second_data got %h want c3c3c3c3c2c2c2c2", out_rsp_data & m5); end
    cyc();
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL ilv_idle got %b want 1", idle); end
  endtask

  task automatic test_backpressure();
    out_rsp_ready = 1'b0;
    alloc_en = 1'b1; alloc_idx = 3'd6; alloc_mask = 4'b0001;
    cyc();
    alloc_idx = 3'd7;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0001; in_rsp_tag = 8'h06;
    in_rsp_data = {96'h0, 32'hF6F6_F6F6};
    cyc();
    in_rsp_tag = 8'h07; in_rsp_data = {96'h0, 32'hF7F7_F7F7};
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (in_rsp_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_rsp_ready); end
      n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h06 || out_rsp_data[31:0] !== 32'hF6F6_F6F6)
        begin n_err++; $display("FAIL bp_hold[%0d] got v=%b tag=%h d=%h want v=1 tag=06 d=f6f6f6f6", i, out_rsp_valid, out_rsp_tag, out_rsp_data[31:0]); end
      cyc();
    end
    out_rsp_ready = 1'b1;
    #1;
    n_vec++; if (in_rsp_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", in_rsp_ready); end
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h07 || out_rsp_data[31:0] !== 32'hF7F7_F7F7)
      begin n_err++; $display("FAIL bp_next got v=%b tag=%h d=%h want v=1 tag=07 d=f7f7f7f7", out_rsp_valid, out_rsp_tag, out_rsp_data[31:0]); end
    cyc();
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL bp_idle got %b want 1", idle); end
  endtask

  task automatic test_realloc_same();
    logic [127:0] m = {32'hFFFF_FFFF, 64'h0, 32'hFFFF_FFFF};
    alloc_en = 1'b1; alloc_idx = 3'd3; alloc_mask = 4'b1001;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b1000; in_rsp_tag = 8'h03;
    in_rsp_data = {32'h3333_0003, 96'h0};
    cyc();
    in_rsp_mask = 4'b0001; in_rsp_tag = 8'h13; in_rsp_data = {96'h0, 32'h3333_0000};
    alloc_en = 1'b1; alloc_idx = 3'd3; alloc_mask = 4'b0100;
    cyc();
    alloc_en = 1'b0; in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h13 || out_rsp_mask !== 4'b1001)
      begin n_err++; $display("FAIL realloc_out got v=%b tag=%h mask=%b want v=1 tag=13 mask=1001", out_rsp_valid, out_rsp_tag, out_rsp_mask); end
    n_vec++; if ((out_rsp_data & m) !== {32'h3333_0003, 64'h0, 32'h3333_0000})
      begin n_err++; $display("FAIL realloc_data got %h want 33330003..33330000", out_rsp_data & m); end
    cyc();
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL realloc_armed got idle=%b want 0", idle); end
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0100; in_rsp_tag = 8'h23;
    in_rsp_data = {32'h0, 32'h3333_0002, 64'h0};
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_tag !== 8'h23 || out_rsp_mask !== 4'b0100 || out_rsp_data[95:64] !== 32'h3333_0002)
      begin n_err++; $display("FAIL realloc_second got v=%b tag=%h mask=%b d=%h want v=1 tag=23 mask=0100 d=33330002", out_rsp_valid, out_rsp_tag, out_rsp_mask, out_rsp_data[95:64]); end
    cyc();
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL realloc_idle got %b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    alloc_en = 1'b1; alloc_idx = 3'd4; alloc_mask = 4'b1111;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0011; in_rsp_tag = 8'h04;
    in_rsp_data = {64'h0, 32'h4444_0001, 32'h4444_0000};
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b0 || idle !== 1'b0)
      begin n_err++; $display("FAIL rmid_pre got v=%b idle=%b want v=0 idle=0", out_rsp_valid, idle); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    n_vec++; if (out_rsp_valid !== 1'b0 || idle !== 1'b1)
      begin n_err++; $display("FAIL rmid_post got v=%b idle=%b want v=0 idle=1", out_rsp_valid, idle); end
    alloc_en = 1'b1; alloc_idx = 3'd4; alloc_mask = 4'b0001;
    cyc();
    alloc_en = 1'b0;
    in_rsp_valid = 1'b1; in_rsp_mask = 4'b0001; in_rsp_tag = 8'h04;
    in_rsp_data = {96'h0, 32'h4444_AAAA};
    cyc();
    in_rsp_valid = 1'b0;
    n_vec++; if (out_rsp_valid !== 1'b1 || out_rsp_mask !== 4'b0001 || out_rsp_data[31:0] !== 32'h4444_AAAA)
      begin n_err++; $display("FAIL rmid_realloc got v=%b mask=%b d=%h want v=1 mask=0001 d=4444aaaa", out_rsp_valid, out_rsp_mask, out_rsp_data[31:0]); end
    cyc();
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle got %b want 1", idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_interleave();
    test_backpressure();
    test_realloc_same();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
